// File: rtl/xnor_compare_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xnor_compare_pkg
// Description : Shared constants and the popcount helper for xnor_compare_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package xnor_compare_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int MB_W      = $clog2(WIDTH_DEF + 1);
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

    // popcount works on a fixed-width container; callers zero-extend, so WIDTH <= POP_MAX_W
    localparam int POP_MAX_W = 64;
    localparam int POP_CNT_W = $clog2(POP_MAX_W + 1);

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [POP_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + POP_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xnor_compare_pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT_VAL = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != SAT_VAL)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/xnor_compare_pipe.sv
`default_nettype none
// ============================================================================
// Module      : xnor_compare_pipe
// Description : Two-stage word comparator: bitwise XNOR, all-equal flag,
//               matching-bit count and saturating eq/neq event counters.
//               Optional mismatch capture enabled by XNOR_COMPARE_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module xnor_compare_pipe
    import xnor_compare_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    output logic [WIDTH-1:0]             O,
    output logic                         out_valid,
    output logic                         eq,
    output logic [$clog2(WIDTH+1)-1:0]   match_bits,
    output logic [CNT_W-1:0]             eq_count,
    output logic [CNT_W-1:0]             neq_count
`ifdef XNOR_COMPARE_STICKY_EN
    ,
    output logic                         mm_sticky,
    output logic [WIDTH-1:0]             first_mm
`endif
);

    localparam int MATCH_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   x1_q, x1_d;
    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic               eq_q, eq_d;
    logic [MATCH_W-1:0] mb_q, mb_d;
    logic               ov_q, ov_d;

    always_comb begin
        x1_d = x1_q;
        v1_d = in_valid;
        if (in_valid) begin
            x1_d = A ~^ B;
        end

        // stage 2 holds its word when nothing new arrives
        o_d  = o_q;
        eq_d = eq_q;
        mb_d = mb_q;
        ov_d = v1_q;
        if (v1_q) begin
            o_d  = x1_q;
            eq_d = &x1_q;
            mb_d = MATCH_W'(popcount(POP_MAX_W'(x1_q)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x1_q <= '0;
            v1_q <= 1'b0;
            o_q  <= '0;
            eq_q <= 1'b0;
            mb_q <= '0;
            ov_q <= 1'b0;
        end else begin
            x1_q <= x1_d;
            v1_q <= v1_d;
            o_q  <= o_d;
            eq_q <= eq_d;
            mb_q <= mb_d;
            ov_q <= ov_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (ov_q & eq_q),
        .count (eq_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_neq_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (ov_q & ~eq_q),
        .count (neq_count)
    );

`ifdef XNOR_COMPARE_STICKY_EN
    logic             mm_sticky_q, mm_sticky_d;
    logic [WIDTH-1:0] first_mm_q, first_mm_d;

    always_comb begin
        mm_sticky_d = mm_sticky_q;
        first_mm_d  = first_mm_q;
        if (clr) begin
            mm_sticky_d = 1'b0;
        end else if (ov_q && !eq_q && !mm_sticky_q) begin
            mm_sticky_d = 1'b1;
            first_mm_d  = o_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mm_sticky_q <= 1'b0;
            first_mm_q  <= '0;
        end else begin
            mm_sticky_q <= mm_sticky_d;
            first_mm_q  <= first_mm_d;
        end
    end

    assign mm_sticky = mm_sticky_q;
    assign first_mm  = first_mm_q;
`endif

    assign O          = o_q;
    assign out_valid  = ov_q;
    assign eq         = eq_q;
    assign match_bits = mb_q;

endmodule
`default_nettype wire

// File: tb/tb_xnor_compare_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_xnor_compare_pipe
// Description : Self-checking bench for xnor_compare_pipe (WIDTH=8 with
//               CNT_W=16 and CNT_W=2, plus WIDTH=1); XNOR_COMPARE_STICKY_EN aware.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xnor_compare_pipe;
    import xnor_compare_pkg::*;

    localparam int SAT_MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;

    logic [7:0]           o, o_s;
    logic                 ov, eq, ov_s, eq_s;
    logic [MB_W-1:0]      mb, mb_s;
    logic [CNT_W_DEF-1:0] eqc, neqc, eqc1, neqc1;
    logic [1:0]           eqc_s, neqc_s;
    logic [0:0]           o1, mb1;
    logic                 ov1, eq1;
`ifdef XNOR_COMPARE_STICKY_EN
    logic       stk_o, stk_o_s, stk_o1;
    logic [7:0] fmm_o, fmm_o_s;
    logic [0:0] fmm_o1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xnor_compare_pipe #(.WIDTH(WIDTH_DEF), .CNT_W(CNT_W_DEF)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A), .B(B),
        .O(o), .out_valid(ov), .eq(eq), .match_bits(mb),
        .eq_count(eqc), .neq_count(neqc)
`ifdef XNOR_COMPARE_STICKY_EN
        , .mm_sticky(stk_o), .first_mm(fmm_o)
`endif
    );

    xnor_compare_pipe #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A), .B(B),
        .O(o_s), .out_valid(ov_s), .eq(eq_s), .match_bits(mb_s),
        .eq_count(eqc_s), .neq_count(neqc_s)
`ifdef XNOR_COMPARE_STICKY_EN
        , .mm_sticky(stk_o_s), .first_mm(fmm_o_s)
`endif
    );

    xnor_compare_pipe #(.WIDTH(1), .CNT_W(CNT_W_DEF)) dut_w1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .A(A[0:0]), .B(B[0:0]),
        .O(o1), .out_valid(ov1), .eq(eq1), .match_bits(mb1),
        .eq_count(eqc1), .neq_count(neqc1)
`ifdef XNOR_COMPARE_STICKY_EN
        , .mm_sticky(stk_o1), .first_mm(fmm_o1)
`endif
    );

    // reference model: words in flight and the visible result
    logic       pend, e_ov, e_eq;
    logic [7:0] pv, e_o;
    int         e_mb;
    int         ce, cn, ce_s, cn_s, ce1, cn1;
`ifdef XNOR_COMPARE_STICKY_EN
    logic       stk, stk1;
    logic [7:0] fmm;
    logic       fmm1;
`endif

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend = 1'b0; pv = '0; e_ov = 1'b0; e_eq = 1'b0; e_o = '0; e_mb = 0;
        ce = 0; cn = 0; ce_s = 0; cn_s = 0; ce1 = 0; cn1 = 0;
`ifdef XNOR_COMPARE_STICKY_EN
        stk = 1'b0; stk1 = 1'b0; fmm = '0; fmm1 = 1'b0;
`endif
    endtask

    task automatic step(input logic r, input logic c, input logic iv,
                        input logic [7:0] a, input logic [7:0] b);
        rst = r; clr = c; in_valid = iv; A = a; B = b;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (c) begin
                ce = 0; cn = 0; ce_s = 0; cn_s = 0; ce1 = 0; cn1 = 0;
`ifdef XNOR_COMPARE_STICKY_EN
                stk = 1'b0; stk1 = 1'b0;
`endif
            end else if (e_ov) begin
                if (e_eq) begin ce = sat_inc(ce, CNT_MAX); ce_s = sat_inc(ce_s, SAT_MAX); end
                else      begin cn = sat_inc(cn, CNT_MAX); cn_s = sat_inc(cn_s, SAT_MAX); end
                if (e_o[0]) ce1 = sat_inc(ce1, CNT_MAX);
                else        cn1 = sat_inc(cn1, CNT_MAX);
`ifdef XNOR_COMPARE_STICKY_EN
                if (!e_eq && !stk) begin stk = 1'b1; fmm = e_o; end
                if (!e_o[0] && !stk1) begin stk1 = 1'b1; fmm1 = e_o[0]; end
`endif
            end
            e_ov = pend;
            if (pend) begin
                e_o  = pv;
                e_eq = (pv == 8'hFF);
                e_mb = $countones(pv);
            end
            pend = iv;
            if (iv) pv = a ~^ b;
        end
        #1;
        check("out_valid", 32'(ov), 32'(e_ov));
        check("O",         32'(o),  32'(e_o));
        check("eq",        32'(eq), 32'(e_eq));
        check("match_bits",32'(mb), 32'(e_mb));
        check("eq_count",  32'(eqc),  32'(ce));
        check("neq_count", 32'(neqc), 32'(cn));
        check("s_out_valid", 32'(ov_s), 32'(e_ov));
        check("s_O",         32'(o_s),  32'(e_o));
        check("s_eq",        32'(eq_s), 32'(e_eq));
        check("s_match_bits",32'(mb_s), 32'(e_mb));
        check("s_eq_count",  32'(eqc_s),  32'(ce_s));
        check("s_neq_count", 32'(neqc_s), 32'(cn_s));
        check("w1_out_valid", 32'(ov1), 32'(e_ov));
        check("w1_O",         32'(o1),  32'(e_o[0]));
        check("w1_eq",        32'(eq1), 32'(e_o[0]));
        check("w1_match_bits",32'(mb1), 32'(e_o[0]));
        check("w1_eq_count",  32'(eqc1),  32'(ce1));
        check("w1_neq_count", 32'(neqc1), 32'(cn1));
`ifdef XNOR_COMPARE_STICKY_EN
        check("mm_sticky",    32'(stk_o),   32'(stk));
        check("first_mm",     32'(fmm_o),   32'(fmm));
        check("s_mm_sticky",  32'(stk_o_s), 32'(stk));
        check("s_first_mm",   32'(fmm_o_s), 32'(fmm));
        check("w1_mm_sticky", 32'(stk_o1),  32'(stk1));
        check("w1_first_mm",  32'(fmm_o1),  32'(fmm1));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] ra, rb;
        model_reset();

        // reset state
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h12, 8'h12);
        // single equal word
        step(1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5);
        idle(3);
        check("t1_eq_count", 32'(eqc), 32'd1);
        check("t1_O_hold",   32'(o),   32'hFF);

        // unequal words
        step(1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F);
        step(1'b0, 1'b0, 1'b1, 8'h81, 8'h80);
        idle(1);
        check("t2_O_FE", 32'(o), 32'hFE);
        check("t2_mb_7", 32'(mb), 32'd7);
        idle(2);

        // 10 words, 6 equal and 4 unequal, with gaps
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = (i % 5 == 1 || i % 5 == 3) ? ra ^ 8'(1 << $urandom_range(0, 7)) : ra;
            step(1'b0, 1'b0, 1'b1, ra, rb);
            if (i % 3 == 0) idle(1);
        end
        idle(3);
        check("t3_eq_count",  32'(eqc),  32'd6);
        check("t3_neq_count", 32'(neqc), 32'd4);

        // saturation on the 2-bit counter, then clr against an increment
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C);
        idle(3);
        check("t4_sat", 32'(eqc_s), 32'd3);
        step(1'b0, 1'b0, 1'b1, 8'h77, 8'h77);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("t4_clr_wins", 32'(eqc_s), 32'd0);
        idle(1);

        // reset with two words in flight
        step(1'b0, 1'b0, 1'b1, 8'h11, 8'h11);
        step(1'b0, 1'b0, 1'b1, 8'h22, 8'h23);
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        idle(3);
        check("t5_no_count", 32'(eqc + neqc), 32'd0);

        // first-mismatch capture sequence
        step(1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h3C, 8'h3D);
        step(1'b0, 1'b0, 1'b1, 8'h00, 8'hFF);
        idle(3);
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        idle(1);

        // random traffic with occasional clr and rst
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ 8'(1 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), ra, rb);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
